// File: rtl/range_dispatcher.sv
// Splits inclusive value ranges into fixed-size chunks and hands each chunk to the next
// idle checker lane in round-robin order; raises a sticky done once the job has drained.
module range_dispatcher #(
    parameter int unsigned LANES           = 8,
    parameter int unsigned VALUE_WIDTH     = 64,
    parameter int unsigned CHUNK_LOG2      = 10,
    parameter int unsigned ISSUE_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [VALUE_WIDTH-1:0]     in_lo,
    input  logic [VALUE_WIDTH-1:0]     in_hi,
    input  logic                       in_last,
    input  logic [LANES-1:0]           lane_idle,
    output logic [LANES-1:0]           lane_start,
    output logic [VALUE_WIDTH-1:0]     lane_lo,
    output logic [VALUE_WIDTH-1:0]     lane_hi,
    output logic                       done,
    output logic [ISSUE_CNT_WIDTH-1:0] chunks_issued
);

    localparam int unsigned PtrW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [VALUE_WIDTH:0] ChunkM1 =
        ((VALUE_WIDTH + 1)'(1) << CHUNK_LOG2) - (VALUE_WIDTH + 1)'(1);

    typedef enum logic [1:0] {StIdle, StSplit, StDrain, StDone} state_e;

    state_e                     state_q, state_d;
    logic [PtrW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [LANES-1:0]           recent_start_q, recent_start_d;
    logic [LANES-1:0]           lane_start_q, lane_start_d;
    logic [VALUE_WIDTH-1:0]     lane_lo_q, lane_lo_d;
    logic [VALUE_WIDTH-1:0]     lane_hi_q, lane_hi_d;
    logic                       done_q, done_d;
    logic [ISSUE_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [VALUE_WIDTH-1:0]     cur_q, cur_d;
    logic [VALUE_WIDTH-1:0]     end_q, end_d;
    logic                       last_q, last_d;

    logic [LANES-1:0]   eligible;
    logic               found;
    logic [PtrW-1:0]    grant;
    logic [PtrW:0]      scan_sum;
    logic [PtrW-1:0]    scan_idx;
    logic [VALUE_WIDTH:0] cend;

    // A lane started last cycle may not have dropped lane_idle yet, so mask it for one cycle.
    assign eligible = lane_idle & ~recent_start_q;
    // One extra bit so a chunk reaching the all-ones value cannot wrap to zero.
    assign cend     = {1'b0, cur_q} + ChunkM1;

    always_comb begin
        found    = 1'b0;
        grant    = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PtrW + 1)'(k);
            if (scan_sum >= (PtrW + 1)'(LANES)) begin
                scan_sum = scan_sum - (PtrW + 1)'(LANES);
            end
            scan_idx = scan_sum[PtrW-1:0];
            if (!found && eligible[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        recent_start_d = lane_start_q;
        lane_start_d   = '0;
        lane_lo_d      = lane_lo_q;
        lane_hi_d      = lane_hi_q;
        cnt_d          = cnt_q;
        cur_d          = cur_q;
        end_d          = end_q;
        last_d         = last_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (in_lo > in_hi) begin
                        if (in_last) state_d = StDrain;
                    end else begin
                        cur_d   = in_lo;
                        end_d   = in_hi;
                        last_d  = in_last;
                        state_d = StSplit;
                    end
                end
            end
            StSplit: begin
                if (found) begin
                    lane_start_d[grant] = 1'b1;
                    rr_ptr_d  = (grant == PtrW'(LANES - 1)) ? '0 : grant + PtrW'(1);
                    lane_lo_d = cur_q;
                    cnt_d     = cnt_q + ISSUE_CNT_WIDTH'(1);
                    if (cend >= {1'b0, end_q}) begin
                        lane_hi_d = end_q;
                        state_d   = last_q ? StDrain : StIdle;
                    end else begin
                        lane_hi_d = cend[VALUE_WIDTH-1:0];
                        cur_d     = cend[VALUE_WIDTH-1:0] + VALUE_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                if ((&lane_idle) && (recent_start_q == '0) && (lane_start_q == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            recent_start_q <= '0;
            lane_start_q   <= '0;
            lane_lo_q      <= '0;
            lane_hi_q      <= '0;
            done_q         <= 1'b0;
            cnt_q          <= '0;
            cur_q          <= '0;
            end_q          <= '0;
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            recent_start_q <= recent_start_d;
            lane_start_q   <= lane_start_d;
            lane_lo_q      <= lane_lo_d;
            lane_hi_q      <= lane_hi_d;
            done_q         <= done_d;
            cnt_q          <= cnt_d;
            cur_q          <= cur_d;
            end_q          <= end_d;
            last_q         <= last_d;
        end
    end

    assign in_ready      = (state_q == StIdle);
    assign lane_start    = lane_start_q;
    assign lane_lo       = lane_lo_q;
    assign lane_hi       = lane_hi_q;
    assign done          = done_q;
    assign chunks_issued = cnt_q;

endmodule

// File: tb/tb_range_dispatcher.sv
// Scoreboard bench for range_dispatcher: expected chunks are queued when a range is sent and
// popped when lane_start pulses; a small lane model drives lane_idle.
module tb_range_dispatcher;

    localparam int unsigned LANES = 8;
    localparam int unsigned VW    = 64;
    localparam int unsigned CW    = 32;
    localparam int unsigned BUSY  = 3;

    typedef struct {
        logic [LANES-1:0] onehot;
        logic [VW-1:0]    lo;
        logic [VW-1:0]    hi;
    } chunk_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [VW-1:0]    in_lo;
    logic [VW-1:0]    in_hi;
    logic             in_last;
    logic [LANES-1:0] lane_idle;
    logic [LANES-1:0] lane_start;
    logic [VW-1:0]    lane_lo;
    logic [VW-1:0]    lane_hi;
    logic             done;
    logic [CW-1:0]    chunks_issued;

    chunk_t           exp_q[$];
    int               exp_ptr;
    int               n_tests;
    int               n_fail;
    int               pulses;
    int               cyc;
    int               first_cyc;
    int               last_cyc;
    logic [LANES-1:0] hold;
    int               busy[LANES];

    range_dispatcher #(
        .LANES          (LANES),
        .VALUE_WIDTH    (VW),
        .CHUNK_LOG2     (10),
        .ISSUE_CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lo        (in_lo),
        .in_hi        (in_hi),
        .in_last      (in_last),
        .lane_idle    (lane_idle),
        .lane_start   (lane_start),
        .lane_lo      (lane_lo),
        .lane_hi      (lane_hi),
        .done         (done),
        .chunks_issued(chunks_issued)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_chunk(input int lane, input logic [VW-1:0] lo, input logic [VW-1:0] hi);
        chunk_t c;
        c.onehot = LANES'(1) << lane;
        c.lo     = lo;
        c.hi     = hi;
        exp_q.push_back(c);
    endtask

    // Reference split assuming every lane is free when the round-robin pointer reaches it.
    task automatic model_range(input logic [VW-1:0] lo, input logic [VW-1:0] hi);
        logic [VW:0]   cend;
        logic [VW-1:0] cur;
        if (lo > hi) return;
        cur = lo;
        for (int n = 0; n < 64; n++) begin
            cend = {1'b0, cur} + 65'd1023;
            if (cend >= {1'b0, hi}) begin
                push_chunk(exp_ptr, cur, hi);
                exp_ptr = (exp_ptr + 1) % LANES;
                break;
            end
            push_chunk(exp_ptr, cur, cend[VW-1:0]);
            exp_ptr = (exp_ptr + 1) % LANES;
            cur = cend[VW-1:0] + 64'd1;
        end
    endtask

    task automatic monitor();
        chunk_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pulses = 0;
                for (int i = 0; i < LANES; i++) busy[i] = 0;
            end else begin
                if (lane_start != '0) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_pulse", 64'(lane_start), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("lane_start", 64'(lane_start), 64'(e.onehot));
                        check_eq("lane_lo", lane_lo, e.lo);
                        check_eq("lane_hi", lane_hi, e.hi);
                    end
                    pulses++;
                    check_eq("chunks_issued", 64'(chunks_issued), 64'(pulses));
                    if (pulses == 1) first_cyc = cyc;
                    last_cyc = cyc;
                end
                for (int i = 0; i < LANES; i++) begin
                    if (lane_start[i]) busy[i] = BUSY;
                    else if (busy[i] != 0) busy[i]--;
                end
            end
            for (int i = 0; i < LANES; i++) lane_idle[i] = (busy[i] == 0) && !hold[i];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_lane_start"}, 64'(lane_start), 64'd0);
        check_eq({tag, "_lane_lo"}, lane_lo, 64'd0);
        check_eq({tag, "_lane_hi"}, lane_hi, 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_chunks"}, 64'(chunks_issued), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        hold     = '0;
        exp_q.delete();
        exp_ptr  = 0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        reset = 1'b0;
    endtask

    task automatic send_range(input logic [VW-1:0] lo, input logic [VW-1:0] hi, input logic last);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_lo    = lo;
        in_hi    = hi;
        in_last  = last;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_lo    = '0;
        in_hi    = '0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check_eq({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_chunks(input int k);
        int n;
        n = 0;
        while (chunks_issued != CW'(k) && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("wait_chunks", 64'(chunks_issued), 64'(k));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        first_cyc = 0;
        last_cyc  = 0;
        pulses    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_lo     = '0;
        in_hi     = '0;
        in_last   = 1'b0;
        hold      = '0;
        lane_idle = '1;
        for (int i = 0; i < LANES; i++) busy[i] = 0;
        fork
            monitor();
        join_none

        // Single small range
        do_reset();
        push_chunk(0, 64'd5, 64'd100);
        send_range(64'd5, 64'd100, 1'b1);
        check_eq("t1_done_early", 64'(done), 64'd0);
        wait_done("t1");
        check_eq("t1_chunks", 64'(chunks_issued), 64'd1);

        // Three exact chunks on consecutive cycles
        do_reset();
        push_chunk(0, 64'd0, 64'd1023);
        push_chunk(1, 64'd1024, 64'd2047);
        push_chunk(2, 64'd2048, 64'd3071);
        send_range(64'd0, 64'd3071, 1'b1);
        wait_done("t2");
        check_eq("t2_chunks", 64'(chunks_issued), 64'd3);
        check_eq("t2_consecutive", 64'(last_cyc - first_cyc), 64'd2);

        // Empty ranges
        do_reset();
        send_range(64'd10, 64'd9, 1'b0);
        check_eq("t3_stay_idle", 64'(in_ready), 64'd1);
        send_range(64'd10, 64'd9, 1'b1);
        check_eq("t3_drain", 64'(in_ready), 64'd0);
        wait_done("t3");
        check_eq("t3_chunks", 64'(chunks_issued), 64'd0);

        // Stall with every lane busy, then only lane 5 frees up
        do_reset();
        hold = '1;
        send_range(64'd0, 64'd100, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        check_eq("t4_stall_chunks", 64'(chunks_issued), 64'd0);
        check_eq("t4_stall_busy", 64'(in_ready), 64'd0);
        push_chunk(5, 64'd0, 64'd100);
        exp_ptr = 6;
        hold = ~LANES'(8'h20);
        wait_chunks(1);
        hold = '0;
        model_range(64'd2000, 64'd2000);
        send_range(64'd2000, 64'd2000, 1'b1);
        wait_done("t4");
        check_eq("t4_chunks", 64'(chunks_issued), 64'd2);

        // Range ending at all-ones
        do_reset();
        push_chunk(0, 64'hFFFF_FFFF_FFFF_FA24, 64'hFFFF_FFFF_FFFF_FE23);
        push_chunk(1, 64'hFFFF_FFFF_FFFF_FE24, 64'hFFFF_FFFF_FFFF_FFFF);
        send_range(64'hFFFF_FFFF_FFFF_FA24, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_done("t5");
        check_eq("t5_chunks", 64'(chunks_issued), 64'd2);

        // Back-to-back random ranges
        do_reset();
        for (int r = 0; r < 5; r++) begin
            logic [VW-1:0] lo;
            logic [VW-1:0] hi;
            lo = {$urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF;
            hi = lo + 64'($urandom_range(0, 4500));
            model_range(lo, hi);
            send_range(lo, hi, r == 4);
        end
        wait_done("t6");

        // Asynchronous reset during the second chunk of a long range
        do_reset();
        model_range(64'd0, 64'd10239);
        send_range(64'd0, 64'd10239, 1'b1);
        wait_chunks(2);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("t7_async");
        exp_q.delete();
        exp_ptr = 0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        push_chunk(0, 64'd0, 64'd0);
        send_range(64'd0, 64'd0, 1'b1);
        wait_done("t7");
        check_eq("t7_chunks", 64'(chunks_issued), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
